// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states, default framing
// constants and the image length limit derived from the address width.
package boot_pkg;

  localparam int unsigned BOOT_ADDR_W    = 14;
  localparam logic [7:0]  BOOT_SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CKSUM,
    DONE,
    ERROR
  } boot_state_e;

  // Largest legal word count for a given address width (one word per address).
  function automatic logic [16:0] max_words(input int unsigned addr_w);
    return 17'(1) << addr_w;
  endfunction

  localparam logic [16:0] BOOT_MAX_WORDS = max_words(BOOT_ADDR_W);

endpackage

// File: rtl/boot_cksum.sv
// Running modulo-256 frame checksum: cleared while idle, accumulates each
// accepted byte, and flags when the byte on the bus would bring the sum to zero.
module boot_cksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_pass
);

  logic [7:0] r_sum;
  logic [7:0] w_sum_next;

  assign w_sum_next = r_sum + i_byte;
  assign o_pass     = (w_sum_next == 8'h00);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= w_sum_next;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a framed UART byte stream into instruction memory and releases the CPU
// once the image is complete. Define BOOT_CHECKSUM_EN to require a trailing checksum byte.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = BOOT_ADDR_W,
  parameter logic [7:0]  SYNC_BYTE = BOOT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        boot_req,
  output logic        debug,
  output logic [15:0] in_addr,
  output logic [15:0] wr_instr,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] MAX_WORDS = max_words(ADDR_W);

  boot_state_e       r_state;
  logic              r_rx_ready;
  logic              r_debug;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wr_instr;
  logic [7:0]        r_len_hi;
  logic [7:0]        r_data_hi;
  logic [16:0]       r_words;

  logic              w_accept;
  logic [16:0]       w_len;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_len    = {1'b0, r_len_hi, rx_data};

  assign rx_ready = r_rx_ready;
  assign debug    = r_debug;
  assign in_addr  = 16'(r_addr);
  assign wr_instr = r_wr_instr;
  assign cpu_rst  = r_cpu_rst;
  assign done     = r_done;
  assign err      = r_err;

`ifdef BOOT_CHECKSUM_EN
  logic w_ck_clear;
  logic w_ck_add;
  logic w_ck_pass;

  // The sum covers length and data bytes; the sync byte is deliberately excluded.
  assign w_ck_clear = (r_state == IDLE);
  assign w_ck_add   = w_accept && (r_state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO});

  boot_cksum u_cksum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_ck_clear),
    .i_add   (w_ck_add),
    .i_byte  (rx_data),
    .o_pass  (w_ck_pass)
  );
`endif

  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // a blocking assignment would let later statements see this cycle's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rx_ready <= 1'b1;
      r_debug    <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wr_instr <= 16'h0000;
      r_len_hi   <= 8'h00;
      r_data_hi  <= 8'h00;
      r_words    <= 17'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && rx_data == SYNC_BYTE) begin
            r_state <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= rx_data;
            r_state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (w_accept) begin
            if (w_len == 17'd0 || w_len > MAX_WORDS) begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end else begin
              r_words <= w_len;
              r_state <= DATA_HI;
            end
          end
        end

        DATA_HI: begin
          if (w_accept) begin
            r_data_hi <= rx_data;
            r_state   <= DATA_LO;
          end
        end

        DATA_LO: begin
          // The write strobe and data become visible on the same edge that enters WRITE.
          if (w_accept) begin
            r_wr_instr <= {r_data_hi, rx_data};
            r_debug    <= 1'b1;
            r_rx_ready <= 1'b0;
            r_state    <= WRITE;
          end
        end

        WRITE: begin
          r_debug    <= 1'b0;
          r_rx_ready <= 1'b1;
          r_addr     <= r_addr + ADDR_W'(1);
          r_words    <= r_words - 17'd1;
          if (r_words != 17'd1) begin
            r_state <= DATA_HI;
          end else begin
`ifdef BOOT_CHECKSUM_EN
            r_state <= CKSUM;
`else
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
`endif
          end
        end

`ifdef BOOT_CHECKSUM_EN
        CKSUM: begin
          if (w_accept) begin
            if (w_ck_pass) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end
          end
        end
`endif

        DONE, ERROR: begin
          // Bytes are still accepted here and simply dropped.
          if (boot_req) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a frame-level model predicts the writes
// and final status, and a per-cycle monitor compares the DUT against it.
module tb_boot_loader;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef enum {K_BAD_LEN, K_OK, K_BAD_CK} kind_e;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        boot_req;
  logic        debug;
  logic [15:0] in_addr;
  logic [15:0] wr_instr;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_writes = 0;
  logic        prev_debug = 1'b0;
  wr_t         exp_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] mem [0:16383];

  boot_loader dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .boot_req (boot_req),
    .debug    (debug),
    .in_addr  (in_addr),
    .wr_instr (wr_instr),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: acts as the instruction memory and checks every cycle's outputs.
  always @(negedge clk) begin : monitor
    wr_t w;
    check("rx_ready_vs_write", {31'd0, rx_ready}, {31'd0, ~debug});
    check("cpu_rst_vs_done", {31'd0, cpu_rst}, {31'd0, ~done});
    check("addr_upper_zero", {30'd0, in_addr[15:14]}, 32'd0);
    if (debug) begin
      n_writes++;
      check("debug_single_cycle", {31'd0, prev_debug}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, debug}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", {16'd0, in_addr}, {16'd0, w.addr});
        check("write_data", {16'd0, wr_instr}, {16'd0, w.data});
      end
      mem[in_addr[13:0]] = wr_instr;
    end
    prev_debug = debug;
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic got;
    rx_valid = 1'b0;
    tick(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    got      = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      rdy = rx_ready;
      @(posedge clk);
      #1;
      got = rdy;
    end
    rx_valid = 1'b0;
    if (!got) check("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
  endtask

  task automatic add_cksum();
    logic [7:0] sum;
    int         s;
    sum = 8'h00;
    s   = 0;
    while (tx_q[s] != 8'hA5) s++;
    for (int i = s + 1; i < tx_q.size(); i++) sum = sum + tx_q[i];
    tx_q.push_back(8'h00 - sum);
  endtask

  // Frame-level model: parse the byte list and predict writes and outcome.
  task automatic model_frame(output kind_e kind);
    int          s;
    int          len;
    logic [15:0] len16;
    logic [7:0]  sum;
    wr_t         w;
    s = 0;
    while (tx_q[s] != 8'hA5) s++;
    len16 = {tx_q[s+1], tx_q[s+2]};
    len   = int'(len16);
    if (len == 0 || len > 16384) begin
      kind = K_BAD_LEN;
      return;
    end
    for (int i = 0; i < len; i++) begin
      w.addr = 16'(i);
      w.data = {tx_q[s+3+2*i], tx_q[s+4+2*i]};
      exp_q.push_back(w);
    end
`ifdef BOOT_CHECKSUM_EN
    sum = 8'h00;
    for (int i = s + 1; i <= s + 3 + 2 * len; i++) sum = sum + tx_q[i];
    kind = (sum == 8'h00) ? K_OK : K_BAD_CK;
`else
    sum  = 8'h00;
    kind = K_OK;
`endif
  endtask

  task automatic run_frame(input string name, input int max_gap);
    kind_e kind;
    model_frame(kind);
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
    @(negedge clk);
    if (kind == K_BAD_LEN || kind == K_BAD_CK) begin
      check({name, "_err_rise"}, {31'd0, err}, 32'd1);
      check({name, "_no_done"}, {31'd0, done}, 32'd0);
    end else begin
`ifndef BOOT_CHECKSUM_EN
      check({name, "_last_write_latency"}, {31'd0, debug}, 32'd1);
      check({name, "_done_after_write"}, {31'd0, done}, 32'd0);
      @(negedge clk);
`endif
      check({name, "_done_rise"}, {31'd0, done}, 32'd1);
      check({name, "_no_err"}, {31'd0, err}, 32'd0);
    end
    check({name, "_cpu_rst"}, {31'd0, cpu_rst}, (kind == K_OK) ? 32'd0 : 32'd1);
    check({name, "_writes_complete"}, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check({name, "_debug"}, {31'd0, debug}, 32'd0);
    check({name, "_in_addr"}, {16'd0, in_addr}, 32'd0);
    check({name, "_wr_instr"}, {16'd0, wr_instr}, 32'd0);
    check({name, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    check({name, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_boot_req(input string name);
    boot_req = 1'b1;
    tick(1);
    boot_req = 1'b0;
    @(negedge clk);
    check({name, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    check({name, "_in_addr"}, {16'd0, in_addr}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int w0;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    boot_req = 1'b0;
    do_reset("por");

    // Basic two-word load.
    clear_mem();
    w0   = n_writes;
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BOOT_CHECKSUM_EN
    add_cksum();
`endif
    run_frame("basic", 0);
    check("basic_nwrites", n_writes - w0, 32'd2);
    check("basic_mem0", {16'd0, mem[0]}, 32'h1234);
    check("basic_mem1", {16'd0, mem[1]}, 32'hABCD);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Bytes in DONE are dropped and done holds.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 1);
    tick(2);
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_drop_nwrites", n_writes - w0, 32'd2);
    pulse_boot_req("restart1");

    // Leading garbage, then a one-word frame.
    clear_mem();
    w0   = n_writes;
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
`ifdef BOOT_CHECKSUM_EN
    add_cksum();
    check("garbage_cksum_byte", {24'd0, tx_q[tx_q.size()-1]}, 32'hB9);
`endif
    run_frame("garbage", 0);
    check("garbage_nwrites", n_writes - w0, 32'd1);
    check("garbage_mem0", {16'd0, mem[0]}, 32'h1234);
    pulse_boot_req("restart2");

    // Zero length is rejected; later bytes are dropped while in ERROR.
    w0   = n_writes;
    tx_q = '{8'hA5, 8'h00, 8'h00};
    run_frame("len0", 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tick(1);
    check("len0_err_hold", {31'd0, err}, 32'd1);
    check("len0_nwrites", n_writes - w0, 32'd0);
    pulse_boot_req("restart3");

    // One past the image limit is rejected the same way.
    tx_q = '{8'hA5, 8'h40, 8'h01};
    run_frame("len4001", 0);
    check("len4001_nwrites", n_writes - w0, 32'd0);
    pulse_boot_req("restart4");

    // Exactly the image limit is accepted as a length.
    send_byte(8'hA5, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    tick(2);
    check("len4000_no_err", {31'd0, err}, 32'd0);
    check("len4000_no_write", n_writes - w0, 32'd0);
    do_reset("after_len4000");

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: word stays written, CPU stays in reset.
    clear_mem();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'hB8};
    run_frame("bad_cksum", 0);
    check("bad_cksum_mem0", {16'd0, mem[0]}, 32'h1234);
    check("bad_cksum_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    pulse_boot_req("restart5");
`else
    clear_mem();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    run_frame("no_cksum", 0);
    check("no_cksum_done", {31'd0, done}, 32'd1);
    pulse_boot_req("restart5");
`endif

    // Three words with random rx_valid gaps.
    clear_mem();
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h55, 8'hAA};
`ifdef BOOT_CHECKSUM_EN
    add_cksum();
`endif
    run_frame("stall", 4);
    check("stall_mem0", {16'd0, mem[0]}, 32'hCAFE);
    check("stall_mem1", {16'd0, mem[1]}, 32'hF00D);
    check("stall_mem2", {16'd0, mem[2]}, 32'h55AA);
    pulse_boot_req("restart6");

    // Reload overwrites from address 0 and leaves the tail untouched.
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef BOOT_CHECKSUM_EN
    add_cksum();
`endif
    run_frame("reload", 2);
    check("reload_mem0", {16'd0, mem[0]}, 32'h1122);
    check("reload_mem1", {16'd0, mem[1]}, 32'h3344);
    check("reload_mem2", {16'd0, mem[2]}, 32'h55AA);
    pulse_boot_req("restart7");

    // Reset in the middle of a frame.
    w0 = n_writes;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    do_reset("midload");
    check("midload_nwrites", n_writes - w0, 32'd0);

    clear_mem();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef BOOT_CHECKSUM_EN
    add_cksum();
`endif
    run_frame("fresh", 1);
    check("fresh_nwrites", n_writes - w0, 32'd1);
    check("fresh_mem0", {16'd0, mem[0]}, 32'hBEEF);

    tick(3);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
